// File: rtl/zdraw_wr_arbiter.sv
// Three-requester round-robin arbiter in front of a single SDRAM write port.
// A winner's address/data slice is latched at grant, presented for one setup
// cycle, then held while oSDRAM_Wr_Req is high. The transaction ends on the
// controller's done pulse or on a bounded timeout, which also reports oErr.
module zdraw_wr_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [2:0]   iReq,
   input  logic [71:0]  iAddr,
   input  logic [191:0] iData,
   output logic [2:0]   oDone,
   output logic         oErr,
   output logic [2:0]   oGrant,
   output logic [23:0]  oSDRAM_Wr_Addr,
   output logic [15:0]  oSDRAM_Wr_Data1,
   output logic [15:0]  oSDRAM_Wr_Data2,
   output logic [15:0]  oSDRAM_Wr_Data3,
   output logic [15:0]  oSDRAM_Wr_Data4,
   output logic         oSDRAM_Wr_Req,
   input  logic         iSDRAM_Wr_Done
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StGrant, StBusy, StDone} state_e;

   state_e          r_state;
   logic [CntW-1:0] r_cnt;
   logic            r_err;
   logic [1:0]      r_last;
   logic [1:0]      r_win;
   logic [2:0]      r_grant;
   logic [2:0]      r_done;
   logic            r_wr_req;
   logic [23:0]     r_addr;
   logic [63:0]     r_data;

   logic [1:0]      w_win;
   logic [2:0]      w_win_oh;
   logic [23:0]     w_addr;
   logic [63:0]     w_data;

   // Round-robin pick: search starts at the requester after the last winner.
   always_comb begin
      w_win = 2'd0;
      case (r_last)
         2'd0:    w_win = iReq[1] ? 2'd1 : (iReq[2] ? 2'd2 : 2'd0);
         2'd1:    w_win = iReq[2] ? 2'd2 : (iReq[0] ? 2'd0 : 2'd1);
         default: w_win = iReq[0] ? 2'd0 : (iReq[1] ? 2'd1 : 2'd2);
      endcase
   end

   // Select the winner's one-hot code and its address/data slice.
   always_comb begin
      w_win_oh = 3'b001;
      w_addr   = iAddr[23:0];
      w_data   = iData[63:0];
      case (w_win)
         2'd1: begin
            w_win_oh = 3'b010;
            w_addr   = iAddr[47:24];
            w_data   = iData[127:64];
         end
         2'd2: begin
            w_win_oh = 3'b100;
            w_addr   = iAddr[71:48];
            w_data   = iData[191:128];
         end
         default: ;
      endcase
   end

   // Transaction FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_err    <= 1'b0;
         r_last   <= 2'd2;
         r_win    <= 2'd0;
         r_grant  <= 3'b000;
         r_done   <= 3'b000;
         r_wr_req <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (|iReq) begin
                  r_win   <= w_win;
                  r_grant <= w_win_oh;
                  r_addr  <= w_addr;
                  r_data  <= w_data;
                  r_state <= StGrant;
               end
            end
            StGrant: begin
               r_wr_req <= 1'b1;
               r_cnt    <= '0;
               r_state  <= StBusy;
            end
            StBusy: begin
               // Done wins over a coincident timeout.
               if (iSDRAM_Wr_Done || (r_cnt == CntMax)) begin
                  r_wr_req <= 1'b0;
                  r_err    <= ~iSDRAM_Wr_Done;
                  r_done   <= r_grant;
                  r_grant  <= 3'b000;
                  r_state  <= StDone;
               end else begin
                  r_cnt <= r_cnt + CntW'(1);
               end
            end
            StDone: begin
               r_done  <= 3'b000;
               r_err   <= 1'b0;
               r_last  <= r_win;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign oDone           = r_done;
   assign oErr            = r_err;
   assign oGrant          = r_grant;
   assign oSDRAM_Wr_Req   = r_wr_req;
   assign oSDRAM_Wr_Addr  = r_addr;
   assign oSDRAM_Wr_Data1 = r_data[15:0];
   assign oSDRAM_Wr_Data2 = r_data[31:16];
   assign oSDRAM_Wr_Data3 = r_data[47:32];
   assign oSDRAM_Wr_Data4 = r_data[63:48];

endmodule

// File: tb/tb_zdraw_wr_arbiter.sv
// Bench for zdraw_wr_arbiter: table of transactions plus hand-written corner
// sequences. Expected completions are queued when stimulus is applied and
// popped when the DUT pulses oDone.
module tb_zdraw_wr_arbiter;

   localparam int unsigned To = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   iReq;
   logic [71:0]  iAddr;
   logic [191:0] iData;
   logic [2:0]   oDone;
   logic         oErr;
   logic [2:0]   oGrant;
   logic [23:0]  oSDRAM_Wr_Addr;
   logic [15:0]  oSDRAM_Wr_Data1;
   logic [15:0]  oSDRAM_Wr_Data2;
   logic [15:0]  oSDRAM_Wr_Data3;
   logic [15:0]  oSDRAM_Wr_Data4;
   logic         oSDRAM_Wr_Req;
   logic         iSDRAM_Wr_Done;

   zdraw_wr_arbiter #(.TIMEOUT_CYCLES(To)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .iReq            (iReq),
      .iAddr           (iAddr),
      .iData           (iData),
      .oDone           (oDone),
      .oErr            (oErr),
      .oGrant          (oGrant),
      .oSDRAM_Wr_Addr  (oSDRAM_Wr_Addr),
      .oSDRAM_Wr_Data1 (oSDRAM_Wr_Data1),
      .oSDRAM_Wr_Data2 (oSDRAM_Wr_Data2),
      .oSDRAM_Wr_Data3 (oSDRAM_Wr_Data3),
      .oSDRAM_Wr_Data4 (oSDRAM_Wr_Data4),
      .oSDRAM_Wr_Req   (oSDRAM_Wr_Req),
      .iSDRAM_Wr_Done  (iSDRAM_Wr_Done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  done;
      logic        err;
      logic [23:0] addr;
      logic [63:0] data;
      int          len;
   } exp_t;

   typedef struct {
      logic [2:0] req;     // bits OR-ed into iReq when the entry starts
      int         delay;   // done in the n-th Wr_Req cycle; 0 = never
      int         winner;
      logic       err;
      int         len;     // expected number of Wr_Req-high cycles
   } vec_t;

   exp_t        sb[$];
   vec_t        vecs[10];
   logic [23:0] addr_tab[3];
   logic [63:0] data_tab[3];

   int         checks = 0;
   int         errors = 0;
   int         n_pop = 0;
   int         n_push = 0;
   int         busy_cnt = 0;
   int         last_run = 0;
   int         sd_delay = 0;
   logic       force_done = 1'b0;
   logic [2:0] drop_mask = 3'b000;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] onehot(input int r);
      logic [2:0] v;
      v    = 3'b000;
      v[r] = 1'b1;
      return v;
   endfunction

   task automatic push_exp(input int r, input logic err, input int len);
      exp_t e;
      e.done = onehot(r);
      e.err  = err;
      e.addr = addr_tab[r];
      e.data = data_tab[r];
      e.len  = len;
      sb.push_back(e);
      n_push++;
   endtask

   // One clock: sample outputs after the edge, score, then drive next inputs.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (oSDRAM_Wr_Req) busy_cnt++;
      else begin
         if (busy_cnt != 0) last_run = busy_cnt;
         busy_cnt = 0;
      end
      check("grant_onehot0", 64'($onehot0(oGrant)), 64'd1);
      check("done_onehot0", 64'($onehot0(oDone)), 64'd1);
      if (oDone != 3'b000) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got %b expected none", oDone);
         end else begin
            e = sb.pop_front();
            n_pop++;
            check("done_mask", 64'(oDone), 64'(e.done));
            check("done_err", 64'(oErr), 64'(e.err));
            check("wr_addr", 64'(oSDRAM_Wr_Addr), 64'(e.addr));
            check("wr_data", {oSDRAM_Wr_Data4, oSDRAM_Wr_Data3, oSDRAM_Wr_Data2,
                              oSDRAM_Wr_Data1}, e.data);
            check("req_len", 64'(last_run), 64'(e.len));
         end
      end else begin
         check("err_without_done", 64'(oErr), 64'd0);
      end
      // Requesters drop iReq the cycle after their done pulse.
      iReq           = iReq & ~drop_mask;
      drop_mask      = oDone;
      iSDRAM_Wr_Done = force_done |
                       (oSDRAM_Wr_Req && (sd_delay != 0) && (busy_cnt == sd_delay));
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (n_pop < n_push && n < 60) begin
         step();
         n++;
      end
      check("done_seen", 64'(n_pop >= n_push), 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_grant"}, 64'(oGrant), 64'd0);
      check({tag, "_done"}, 64'(oDone), 64'd0);
      check({tag, "_err"}, 64'(oErr), 64'd0);
      check({tag, "_wr_req"}, 64'(oSDRAM_Wr_Req), 64'd0);
      check({tag, "_addr"}, 64'(oSDRAM_Wr_Addr), 64'd0);
      check({tag, "_data"}, {oSDRAM_Wr_Data4, oSDRAM_Wr_Data3, oSDRAM_Wr_Data2,
                             oSDRAM_Wr_Data1}, 64'd0);
   endtask

   initial begin
      addr_tab[0] = 24'h123456;
      addr_tab[1] = 24'hFEDCBA;
      addr_tab[2] = 24'h5A5A5A;
      data_tab[0] = 64'h4444_3333_2222_1111;
      data_tab[1] = 64'hA004_A003_A002_A001;
      data_tab[2] = 64'hB004_B003_B002_B001;

      // Last winner starts at 2, so the sequence below is fully determined.
      vecs[0] = '{3'b111, 3,  0, 1'b0, 3};
      vecs[1] = '{3'b000, 4,  1, 1'b0, 4};
      vecs[2] = '{3'b000, 2,  2, 1'b0, 2};
      vecs[3] = '{3'b001, 6,  0, 1'b0, 6};   // single request, done 5 after req rises
      vecs[4] = '{3'b111, 1,  1, 1'b0, 1};
      vecs[5] = '{3'b010, 2,  2, 1'b0, 2};   // requester 1 re-requests, waits turn
      vecs[6] = '{3'b000, 2,  0, 1'b0, 2};
      vecs[7] = '{3'b000, 2,  1, 1'b0, 2};
      vecs[8] = '{3'b100, 0,  2, 1'b1, 16};  // timeout
      vecs[9] = '{3'b010, 16, 1, 1'b0, 16};  // done on the timeout cycle

      rst_n          = 1'b0;
      iReq           = 3'b000;
      iSDRAM_Wr_Done = 1'b0;
      iAddr          = {addr_tab[2], addr_tab[1], addr_tab[0]};
      iData          = {data_tab[2], data_tab[1], data_tab[0]};
      #2;
      check_all_zero("reset");
      step();
      step();
      rst_n = 1'b1;

      // Done pulses while idle must be ignored.
      force_done = 1'b1;
      step();
      step();
      step();
      check("idle_done_grant", 64'(oGrant), 64'd0);
      check("idle_done_req", 64'(oSDRAM_Wr_Req), 64'd0);
      force_done = 1'b0;
      step();

      for (int i = 0; i < 10; i++) begin
         sd_delay = vecs[i].delay;
         iReq     = iReq | vecs[i].req;
         push_exp(vecs[i].winner, vecs[i].err, vecs[i].len);
         step();
         check("grant_latency", 64'(oGrant), 64'(onehot(vecs[i].winner)));
         check("setup_no_req", 64'(oSDRAM_Wr_Req), 64'd0);
         check("setup_addr", 64'(oSDRAM_Wr_Addr), 64'(addr_tab[vecs[i].winner]));
         step();
         check("busy_req", 64'(oSDRAM_Wr_Req), 64'd1);
         wait_done();
         step();
         check("idle_grant", 64'(oGrant), 64'd0);
      end

      // Winner drops iReq mid-BUSY; a non-winner pulses its request meanwhile.
      sd_delay = 4;
      iReq     = 3'b001;
      push_exp(0, 1'b0, 4);
      step();
      step();
      iReq[0] = 1'b0;
      iReq[1] = 1'b1;
      step();
      iReq[1] = 1'b0;
      wait_done();
      step();
      check("drop_idle_grant", 64'(oGrant), 64'd0);
      step();
      check("drop_no_regrant", 64'(oGrant), 64'd0);

      // Asynchronous reset in the middle of BUSY aborts without oDone.
      sd_delay = 0;
      iReq     = 3'b100;
      step();
      step();
      step();
      check("pre_reset_req", 64'(oSDRAM_Wr_Req), 64'd1);
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_busy_reset");
      iReq      = 3'b010;
      drop_mask = 3'b000;
      busy_cnt  = 0;
      step();
      step();
      rst_n    = 1'b1;
      sd_delay = 3;
      push_exp(1, 1'b0, 3);
      step();
      check("post_reset_grant", 64'(oGrant), 64'b010);
      step();
      check("post_reset_req", 64'(oSDRAM_Wr_Req), 64'd1);
      wait_done();
      step();
      step();

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/zdraw_wr_arbiter.md
ZDRAW_WR_ARBITER -- requirements
Module: zdraw_wr_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, the maximum number of BUSY cycles to wait for iSDRAM_Wr_Done before aborting.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port iReq, input, 3 bits: per-requester write request, level, held until the matching oDone bit.
REQ-005 The block SHALL have the port iAddr, input, 72 bits: 3 x 24-bit SDRAM address, Bank(2)+Row(13)+Column(9); requester n occupies bits [24n+23:24n].
REQ-006 The block SHALL have the port iData, input, 192 bits: 3 x 64-bit data; requester n occupies [64n+63:64n], with word1 in the low 16 bits up to word4 in the high 16 bits.
REQ-007 The block SHALL have the port oDone, output, 3 bits: one-cycle done pulse to the granted requester.
REQ-008 The block SHALL have the port oErr, output, 1 bit: one-cycle pulse, coincident with oDone, on timeout abort.
REQ-009 The block SHALL have the port oGrant, output, 3 bits: one-hot current owner; all zero when idle.
REQ-010 The block SHALL have the ports oSDRAM_Wr_Addr (output, 24 bits) and oSDRAM_Wr_Data1..oSDRAM_Wr_Data4 (output, 16 bits each): the write port toward the SDRAM controller.
REQ-011 The block SHALL have the port oSDRAM_Wr_Req, output, 1 bit: SDRAM write request, level.
REQ-012 The block SHALL have the port iSDRAM_Wr_Done, input, 1 bit: SDRAM write-complete pulse.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have the states IDLE, GRANT, BUSY and DONE.
REQ-015 IDLE: if any iReq bit is set, the block SHALL select a winner by round-robin starting at the bit after the last winner (last winner resets to 2, so requester 0 wins first), latch that requester's address and data slice into the SDRAM outputs, set oGrant, and go to GRANT.
REQ-016 GRANT: the block SHALL last exactly 1 cycle with the address and data stable and oSDRAM_Wr_Req=0 (one setup cycle), then go to BUSY.
REQ-017 BUSY: oSDRAM_Wr_Req SHALL be 1, and address and data SHALL be held constant.
REQ-018 BUSY: on iSDRAM_Wr_Done=1 the block SHALL clear oSDRAM_Wr_Req and go to DONE.
REQ-019 BUSY: a cycle counter SHALL start at 0 on BUSY entry; when it reaches TIMEOUT_CYCLES-1 without done, the block SHALL clear oSDRAM_Wr_Req, flag an error and go to DONE.
REQ-020 DONE: the block SHALL last 1 cycle, with oDone[winner]=1, oErr=error flag, and oGrant cleared; it SHALL update the last winner and go to IDLE.
REQ-021 Latency: iReq rising with the block in IDLE in cycle 0 SHALL give oGrant in cycle 1 and oSDRAM_Wr_Req in cycle 2.
REQ-022 Latency: iSDRAM_Wr_Done in cycle k SHALL give oSDRAM_Wr_Req=0 and oDone in cycle k+1, with the block back in IDLE in cycle k+2.
REQ-023 A requester SHALL drop iReq in the cycle after its oDone pulse; IDLE samples iReq in that cycle, so the same requester SHALL NOT be re-granted unless its iReq is still 1.
REQ-024 A winner deasserting iReq mid-transaction SHALL be ignored: the transaction SHALL complete and oDone SHALL still pulse.
REQ-025 iReq changes of non-winners SHALL NOT affect the current transaction.
REQ-026 iSDRAM_Wr_Done in IDLE, GRANT or DONE SHALL be ignored.
REQ-027 iSDRAM_Wr_Done in the same cycle as the timeout count SHALL be treated as success, with oErr=0.
REQ-028 With all 3 requesters continuously requesting, the grant order SHALL be 0,1,2,0,... with no requester starved.
REQ-029 At most one oDone bit SHALL be set in any cycle, and oGrant SHALL be one-hot or zero.

Reset
REQ-030 While rst_n=0, the block SHALL asynchronously force state=IDLE, all outputs to 0, the timeout counter to 0, the error flag to 0, and the last winner to 2.
REQ-031 Reset asserted mid-BUSY SHALL drop oSDRAM_Wr_Req immediately, with no oDone issued.
REQ-032 After rst_n rises, the first edge SHALL evaluate in IDLE.

Verification
REQ-033 Single request: iReq=001, iAddr[23:0]=0x12_3456, data=0x1111/2222/3333/4444, done 5 cycles after oSDRAM_Wr_Req rises -> SDRAM outputs match, oGrant=001, oDone=001 for 1 cycle, oErr=0.
REQ-034 Round-robin: iReq=111 held, each requester dropping after its oDone -> grant order 0,1,2.
REQ-035 Re-request: a requester re-asserting after other requesters are served -> it waits its round-robin turn.
REQ-036 Timeout: TIMEOUT_CYCLES=16, iSDRAM_Wr_Done never asserted -> oSDRAM_Wr_Req high exactly 16 cycles, then oDone and oErr pulse together.
REQ-037 Boundary events: iSDRAM_Wr_Done in IDLE -> no effect; iSDRAM_Wr_Done on the timeout cycle -> oErr=0; winner drops iReq in BUSY -> transaction completes and oDone pulses.
REQ-038 Reset mid-BUSY: rst_n=0 -> all outputs 0 asynchronously; after release, a pending iReq=010 is granted and requester 1 is served.
